// File: rtl/seq_mul_sat_pkg.sv
// Shared types and helpers for the sequential shift-add saturating multiplier.
package seq_mul_sat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIX  = 2'd2,
    ST_OUT  = 2'd3
  } state_e;

  function automatic logic signed [63:0] max_val(input int w);
    return (64'sd1 <<< (w - 1)) - 64'sd1;
  endfunction

  function automatic logic signed [63:0] min_val(input int w);
    return -(64'sd1 <<< (w - 1));
  endfunction

endpackage

// File: rtl/seq_mul_sat_sat_clip.sv
// Combinational clip/wrap of a signed IN_W value into OUT_W bits with overflow flag.
module sat_clip
  import seq_mul_sat_pkg::*;
#(
  parameter int IN_W     = 16,
  parameter int OUT_W    = 8,
  parameter int SATURATE = 1
) (
  input  logic signed [IN_W-1:0]  din,
  output logic        [OUT_W-1:0] dout,
  output logic                    ovf
);

  localparam logic signed [63:0]     MAX64 = max_val(OUT_W);
  localparam logic signed [63:0]     MIN64 = min_val(OUT_W);
  localparam logic signed [IN_W-1:0] MAX_V = MAX64[IN_W-1:0];
  localparam logic signed [IN_W-1:0] MIN_V = MIN64[IN_W-1:0];
  localparam logic [OUT_W-1:0]       MAX_O = MAX64[OUT_W-1:0];
  localparam logic [OUT_W-1:0]       MIN_O = MIN64[OUT_W-1:0];

  always_comb begin
    dout = din[OUT_W-1:0];
    ovf  = 1'b0;
    if (din > MAX_V) begin
      ovf = 1'b1;
      if (SATURATE != 0) dout = MAX_O;
    end else if (din < MIN_V) begin
      ovf = 1'b1;
      if (SATURATE != 0) dout = MIN_O;
    end
  end

endmodule

// File: rtl/seq_mul_sat.sv
// Multi-cycle signed multiplier: one shift-add step per clock on magnitudes,
// then sign fix-up, Q-format scaling and saturate/wrap, with valid/ready on both sides.
module seq_mul_sat
  import seq_mul_sat_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int FRAC     = 0,
  parameter int SATURATE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  state_e           state_q, state_d;
  logic             sign_q, sign_d;
  logic [AW-1:0]    a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             overflow_q, overflow_d;
  logic             out_valid_q, out_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [WIDTH-1:0]     a_abs, b_abs;
  logic signed [AW-1:0] signed_acc, scaled;
  logic [WIDTH-1:0]     clip_val;
  logic                 clip_ovf;

  // Magnitudes as unsigned WIDTH bits; |MIN| = 2^(WIDTH-1) still fits.
  assign a_abs = a[WIDTH-1] ? (-a) : a;
  assign b_abs = b[WIDTH-1] ? (-b) : b;

  // |MIN|*|MIN| = 2^(2W-2) fits in AW signed bits, so negation cannot overflow.
  assign signed_acc = sign_q ? $signed(-acc_q) : $signed(acc_q);
  assign scaled     = signed_acc >>> FRAC;

  sat_clip #(
    .IN_W    (AW),
    .OUT_W   (WIDTH),
    .SATURATE(SATURATE)
  ) u_clip (
    .din (scaled),
    .dout(clip_val),
    .ovf (clip_ovf)
  );

  always_comb begin
    state_d     = state_q;
    sign_d      = sign_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    overflow_d  = overflow_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d  = a[WIDTH-1] ^ b[WIDTH-1];
          a_sh_d  = {{WIDTH{1'b0}}, a_abs};
          b_sh_d  = b_abs;
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        // a is pre-shifted and b consumed LSB-first, equivalent to testing |b|[cnt].
        if (b_sh_q[0]) acc_d = acc_q + a_sh_q;
        a_sh_d = a_sh_q << 1;
        b_sh_d = b_sh_q >> 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        result_d    = clip_val;
        overflow_d  = clip_ovf;
        out_valid_d = 1'b1;
        state_d     = ST_OUT;
      end
      ST_OUT: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    in_ready_d = (state_d == ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sign_q      <= 1'b0;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      result_q    <= '0;
      overflow_q  <= 1'b0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      sign_q      <= sign_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      overflow_q  <= overflow_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_seq_mul_sat.sv
// Scoreboard bench for seq_mul_sat: saturating, wrapping and Q4 instances.
module tb_seq_mul_sat;

  typedef struct {
    logic [7:0] r;
    logic       ov;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] in_valid = 3'b000;
  logic [2:0] in_ready;
  logic [2:0] out_valid;
  logic [2:0] ovf;
  logic [7:0] res [3];
  logic [7:0] a = 8'h00;
  logic [7:0] b = 8'h00;
  logic       out_ready = 1'b1;

  int nvec = 0;
  int nerr = 0;
  exp_t sb0[$];
  exp_t sb1[$];
  exp_t sb2[$];

  always #5 clk = ~clk;

  seq_mul_sat #(.WIDTH(8), .FRAC(0), .SATURATE(1)) u_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a), .b(b), .out_valid(out_valid[0]), .out_ready(out_ready),
    .result(res[0]), .overflow(ovf[0]));

  seq_mul_sat #(.WIDTH(8), .FRAC(0), .SATURATE(0)) u_wrap (
    .clk(clk), .rst(rst), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a), .b(b), .out_valid(out_valid[1]), .out_ready(out_ready),
    .result(res[1]), .overflow(ovf[1]));

  seq_mul_sat #(.WIDTH(8), .FRAC(4), .SATURATE(1)) u_frac (
    .clk(clk), .rst(rst), .in_valid(in_valid[2]), .in_ready(in_ready[2]),
    .a(a), .b(b), .out_valid(out_valid[2]), .out_ready(out_ready),
    .result(res[2]), .overflow(ovf[2]));

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
    end
  endtask

  function automatic int sb_size(input int k);
    case (k)
      0:       return sb0.size();
      1:       return sb1.size();
      default: return sb2.size();
    endcase
  endfunction

  task automatic sb_push(input int k, input logic [7:0] r, input logic ov);
    exp_t e;
    e.r  = r;
    e.ov = ov;
    case (k)
      0:       sb0.push_back(e);
      1:       sb1.push_back(e);
      default: sb2.push_back(e);
    endcase
  endtask

  task automatic check_pop(input int k);
    exp_t e;
    if (sb_size(k) == 0) begin
      nvec++;
      nerr++;
      $display("FAIL unexpected_output inst %0d: result 0x%02h with no expectation queued", k, res[k]);
    end else begin
      case (k)
        0:       e = sb0.pop_front();
        1:       e = sb1.pop_front();
        default: e = sb2.pop_front();
      endcase
      $display("inst %0d out: result=0x%02h overflow=%0b (expect 0x%02h/%0b)", k, res[k], ovf[k], e.r, e.ov);
      chk($sformatf("result_inst%0d", k), 32'(res[k]), 32'(e.r));
      chk($sformatf("overflow_inst%0d", k), 32'(ovf[k]), 32'(e.ov));
    end
  endtask

  // Monitor: the handshake completes on the following rising edge.
  always @(negedge clk) begin
    if (!rst && out_ready) begin
      for (int k = 0; k < 3; k++)
        if (out_valid[k]) check_pop(k);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int k, input logic [7:0] av, input logic [7:0] bv,
                       input bit push, input logic [7:0] er, input logic eov);
    int n = 0;
    while (!in_ready[k] && n < 100) begin
      step();
      n++;
    end
    if (!in_ready[k]) chk("in_ready_timeout", 32'(in_ready[k]), 32'd1);
    if (push) sb_push(k, er, eov);
    $display("inst %0d in: a=0x%02h b=0x%02h", k, av, bv);
    a = av;
    b = bv;
    in_valid[k] = 1'b1;
    step();
    in_valid[k] = 1'b0;
  endtask

  task automatic drain(input int k);
    int n = 0;
    while (sb_size(k) != 0 && n < 200) begin
      step();
      n++;
    end
    if (sb_size(k) != 0) chk("drain_timeout", 32'(sb_size(k)), 32'd0);
    step();
  endtask

  task automatic wait_out_valid(input int k);
    int n = 0;
    while (!out_valid[k] && n < 50) begin
      step();
      n++;
    end
    if (!out_valid[k]) chk("out_valid_timeout", 32'(out_valid[k]), 32'd1);
  endtask

  task automatic check_reset_state(input string nm);
    chk({nm, "_in_ready"}, 32'(in_ready[0]), 32'd1);
    chk({nm, "_out_valid"}, 32'(out_valid[0]), 32'd0);
    chk({nm, "_result"}, 32'(res[0]), 32'd0);
    chk({nm, "_overflow"}, 32'(ovf[0]), 32'd0);
  endtask

  initial begin
    int  cyc;
    bit  rdy_seen;
    repeat (3) step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("rst_in_ready%0d", k), 32'(in_ready[k]), 32'd1);
      chk($sformatf("rst_out_valid%0d", k), 32'(out_valid[k]), 32'd0);
      chk($sformatf("rst_result%0d", k), 32'(res[k]), 32'd0);
    end

    // Latency and in_ready low while busy: 10 * -12 = -120
    issue(0, 8'd10, 8'hF4, 1'b1, 8'h88, 1'b0);
    cyc = 0;
    rdy_seen = 1'b0;
    while (!out_valid[0] && cyc < 50) begin
      if (in_ready[0]) rdy_seen = 1'b1;
      step();
      cyc++;
    end
    chk("latency_edges", 32'(cyc), 32'd9);
    chk("in_ready_low_busy", 32'(rdy_seen), 32'd0);
    drain(0);

    // Saturating instance
    issue(0, 8'd16,  8'd8,   1'b1, 8'h7F, 1'b1); drain(0);
    issue(0, 8'hF0,  8'd8,   1'b1, 8'h80, 1'b0); drain(0);
    issue(0, 8'h80,  8'hFF,  1'b1, 8'h7F, 1'b1); drain(0);
    issue(0, 8'h80,  8'h80,  1'b1, 8'h7F, 1'b1); drain(0);
    issue(0, 8'd0,   8'h80,  1'b1, 8'h00, 1'b0); drain(0);
    issue(0, 8'hF5,  8'd11,  1'b1, 8'h87, 1'b0); drain(0);

    // Wrapping instance
    issue(1, 8'd16,  8'd8,   1'b1, 8'h80, 1'b1); drain(1);
    issue(1, 8'hFD,  8'hFD,  1'b1, 8'h09, 1'b0); drain(1);
    issue(1, 8'd20,  8'hF6,  1'b1, 8'h38, 1'b1); drain(1);

    // Q4 fixed point instance
    issue(2, 8'h18,  8'h28,  1'b1, 8'h3C, 1'b0); drain(2);
    issue(2, 8'hE8,  8'h08,  1'b1, 8'hF4, 1'b0); drain(2);
    issue(2, 8'h7F,  8'h7F,  1'b1, 8'h7F, 1'b1); drain(2);
    issue(2, 8'hFF,  8'h01,  1'b1, 8'hFF, 1'b0); drain(2);

    // Back-pressure: outputs hold, no new accept, even with in_valid alongside out_ready
    out_ready = 1'b0;
    issue(0, 8'd16, 8'd8, 1'b1, 8'h7F, 1'b1);
    wait_out_valid(0);
    for (int i = 0; i < 5; i++) begin
      in_valid[0] = ~in_valid[0];
      a = 8'($urandom);
      b = 8'($urandom);
      step();
      chk("bp_out_valid", 32'(out_valid[0]), 32'd1);
      chk("bp_result", 32'(res[0]), 32'h7F);
      chk("bp_overflow", 32'(ovf[0]), 32'd1);
      chk("bp_in_ready", 32'(in_ready[0]), 32'd0);
    end
    a = 8'd3;
    b = 8'd3;
    in_valid[0] = 1'b1;
    out_ready = 1'b1;
    step();
    in_valid[0] = 1'b0;
    chk("bp_release_out_valid", 32'(out_valid[0]), 32'd0);
    chk("bp_release_in_ready", 32'(in_ready[0]), 32'd1);
    chk("bp_held_result", 32'(res[0]), 32'h7F);
    chk("bp_held_overflow", 32'(ovf[0]), 32'd1);
    step();
    chk("bp_no_accept_in_out", 32'(in_ready[0]), 32'd1);

    // Reset during RUN cycle 3
    issue(0, 8'd10, 8'd10, 1'b0, 8'h00, 1'b0);
    step();
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_reset_state("rst_run");
    issue(0, 8'd7, 8'd7, 1'b1, 8'd49, 1'b0);
    drain(0);

    // Reset while holding in OUT
    out_ready = 1'b0;
    issue(0, 8'd16, 8'd8, 1'b0, 8'h00, 1'b0);
    wait_out_valid(0);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    check_reset_state("rst_out");
    issue(0, 8'd7, 8'd7, 1'b1, 8'd49, 1'b0);
    drain(0);

    for (int k = 0; k < 3; k++)
      chk($sformatf("scoreboard_empty%0d", k), 32'(sb_size(k)), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
